// File: rtl/id_ex_if.sv
// Signal bundle between decode, writeback and the ID/EX pipeline register.
// The master side drives the ID/WB/flush inputs; the slave side is the stage itself.
interface id_ex_if #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
);
    // ID side
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [31:0]       id_imm32;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_memread;
    logic [31:0]       id_busA;
    logic [31:0]       id_busB;
    // WB write port (same signals that drive the register file)
    logic              wb_RegWr;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_busW;
    // EX feedback
    logic              ex_flush;
    // EX side
    logic              ex_valid;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [31:0]       ex_busA;
    logic [31:0]       ex_busB;
    logic [31:0]       ex_imm32;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_memread;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_imm32, id_ctrl, id_memread,
               id_busA, id_busB, wb_RegWr, wb_rd, wb_busW, ex_flush,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_busA, ex_busB, ex_imm32,
               ex_ctrl, ex_memread, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_imm32, id_ctrl, id_memread,
               id_busA, id_busB, wb_RegWr, wb_rd, wb_busW, ex_flush,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_busA, ex_busB, ex_imm32,
               ex_ctrl, ex_memread, stall, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID write-through bypass, load-use stall
// detection, branch flush and a saturating count of stall bubbles.
module id_ex_stage #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic   clk,
    input  logic   rst,
    id_ex_if.slave bus
);
    logic              ex_valid_q;
    logic [4:0]        ex_rs_q;
    logic [4:0]        ex_rt_q;
    logic [4:0]        ex_rd_q;
    logic [31:0]       ex_busA_q;
    logic [31:0]       ex_busB_q;
    logic [31:0]       ex_imm32_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic              ex_memread_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        haz;
    logic        stall;

    // Operand bypass (regfile writes on the edge, so same-cycle reads are stale) and hazard.
    always_comb begin
        op_a = bus.id_busA;
        op_b = bus.id_busB;
        if (bus.wb_RegWr && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs)) begin
            op_a = bus.wb_busW;
        end
        if (bus.wb_RegWr && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rt)) begin
            op_b = bus.wb_busW;
        end
        // r0 is hard-wired to zero whatever the WB port says
        if (bus.id_rs == 5'd0) begin
            op_a = 32'd0;
        end
        if (bus.id_rt == 5'd0) begin
            op_b = 32'd0;
        end
        haz = ex_valid_q && ex_memread_q && (ex_rd_q != 5'd0) && bus.id_valid &&
              ((ex_rd_q == bus.id_rs) || (ex_rd_q == bus.id_rt));
        // A flush kills the dependent instruction anyway, so no need to hold it
        stall = haz && !bus.ex_flush;
    end

    // Pipeline register: reset, then flush bubble, then stall bubble, then capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= 5'd0;
            ex_rt_q      <= 5'd0;
            ex_rd_q      <= 5'd0;
            ex_busA_q    <= 32'd0;
            ex_busB_q    <= 32'd0;
            ex_imm32_q   <= 32'd0;
            ex_ctrl_q    <= '0;
            ex_memread_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else if (bus.ex_flush || stall) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= 5'd0;
            ex_rt_q      <= 5'd0;
            ex_rd_q      <= 5'd0;
            ex_busA_q    <= 32'd0;
            ex_busB_q    <= 32'd0;
            ex_imm32_q   <= 32'd0;
            ex_ctrl_q    <= '0;
            ex_memread_q <= 1'b0;
            // stall is already low whenever flush is high
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_q   <= bus.id_valid;
            ex_rs_q      <= bus.id_rs;
            ex_rt_q      <= bus.id_rt;
            ex_rd_q      <= bus.id_rd;
            ex_busA_q    <= op_a;
            ex_busB_q    <= op_b;
            ex_imm32_q   <= bus.id_imm32;
            // an empty slot must not carry control side effects downstream
            ex_ctrl_q    <= bus.id_valid ? bus.id_ctrl : '0;
            ex_memread_q <= bus.id_memread;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_rs      = ex_rs_q;
    assign bus.ex_rt      = ex_rt_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_busA    = ex_busA_q;
    assign bus.ex_busB    = ex_busB_q;
    assign bus.ex_imm32   = ex_imm32_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.ex_memread = ex_memread_q;
    assign bus.stall      = stall;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a main instance (CNT_W=16) and a narrow-counter
// instance (CNT_W=2) see identical stimulus; a reference model predicts the EX slot.
module tb_id_ex_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    id_ex_if #(.CTRL_W(8), .CNT_W(16)) bus0 ();
    id_ex_if #(.CTRL_W(8), .CNT_W(2))  bus1 ();

    id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus0));
    id_ex_stage #(.CTRL_W(8), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic        memread;
    } ex_t;

    typedef struct packed {
        ex_t         ex;
        logic        stall;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    ex_t         m;
    int unsigned mcnt;
    int unsigned mcnt2;
    bit          known = 1'b0;

    // stimulus variables
    logic        iv, mr, wwe, fl;
    logic [4:0]  rs, rt, rd, wrd;
    logic [31:0] imm, ba, bb, wbw;
    logic [7:0]  ctrl;

    task automatic apply();
        bus0.id_valid = iv;  bus1.id_valid = iv;
        bus0.id_rs = rs;     bus1.id_rs = rs;
        bus0.id_rt = rt;     bus1.id_rt = rt;
        bus0.id_rd = rd;     bus1.id_rd = rd;
        bus0.id_imm32 = imm; bus1.id_imm32 = imm;
        bus0.id_ctrl = ctrl; bus1.id_ctrl = ctrl;
        bus0.id_memread = mr; bus1.id_memread = mr;
        bus0.id_busA = ba;   bus1.id_busA = ba;
        bus0.id_busB = bb;   bus1.id_busB = bb;
        bus0.wb_RegWr = wwe; bus1.wb_RegWr = wwe;
        bus0.wb_rd = wrd;    bus1.wb_rd = wrd;
        bus0.wb_busW = wbw;  bus1.wb_busW = wbw;
        bus0.ex_flush = fl;  bus1.ex_flush = fl;
    endtask

    // value EX should see for a source register read this cycle
    function automatic logic [31:0] operand(logic [4:0] r, logic [31:0] bus_val);
        if (r == 5'd0) return 32'd0;
        if (wwe && wrd != 5'd0 && wrd == r) return wbw;
        return bus_val;
    endfunction

    function automatic bit load_use();
        return m.valid && m.memread && m.rd != 5'd0 && iv && (m.rd == rs || m.rd == rt);
    endfunction

    // one clock: predict, push, advance model
    task automatic step();
        exp_t e;
        bit   stl;
        apply();
        stl = load_use() && !fl;
        if (known) begin
            e.ex = m; e.stall = stl; e.cnt = mcnt[15:0]; e.cnt2 = mcnt2[1:0];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m = '0; mcnt = 0; mcnt2 = 0; known = 1'b1;
        end else if (known) begin
            if (fl || stl) begin
                m = '0;
                if (stl) begin
                    if (mcnt < 65535) mcnt++;
                    if (mcnt2 < 3) mcnt2++;
                end
            end else begin
                m.valid = iv; m.rs = rs; m.rt = rt; m.rd = rd;
                m.a = operand(rs, ba); m.b = operand(rt, bb);
                m.imm = imm; m.ctrl = iv ? ctrl : 8'd0; m.memread = mr;
            end
        end
    endtask

    task automatic nop();
        iv = 0; rs = 0; rt = 0; rd = 0; imm = 0; ctrl = 0; mr = 0; ba = 0; bb = 0;
        wwe = 0; wrd = 0; wbw = 0; fl = 0;
    endtask

    task automatic randomize_inputs();
        iv = ($urandom_range(0, 3) != 0);
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        imm = $urandom; ctrl = 8'($urandom); mr = 1'($urandom);
        ba = $urandom; bb = $urandom;
        wwe = 1'($urandom); wrd = 5'($urandom_range(0, 3)); wbw = $urandom;
        fl = ($urandom_range(0, 7) == 0);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // monitor: the DUT presents a new EX slot every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ex_valid",   32'(bus0.ex_valid),   32'(e.ex.valid));
            chk("ex_rs",      32'(bus0.ex_rs),      32'(e.ex.rs));
            chk("ex_rt",      32'(bus0.ex_rt),      32'(e.ex.rt));
            chk("ex_rd",      32'(bus0.ex_rd),      32'(e.ex.rd));
            chk("ex_busA",    bus0.ex_busA,         e.ex.a);
            chk("ex_busB",    bus0.ex_busB,         e.ex.b);
            chk("ex_imm32",   bus0.ex_imm32,        e.ex.imm);
            chk("ex_ctrl",    32'(bus0.ex_ctrl),    32'(e.ex.ctrl));
            chk("ex_memread", 32'(bus0.ex_memread), 32'(e.ex.memread));
            chk("stall",      32'(bus0.stall),      32'(e.stall));
            chk("stall_cnt",  32'(bus0.stall_cnt),  32'(e.cnt));
            chk("sat_stall",  32'(bus1.stall),      32'(e.stall));
            chk("sat_cnt",    32'(bus1.stall_cnt),  32'(e.cnt2));
        end
    end

    initial begin
        nop();
        // reset held two cycles with random inputs
        rst = 1;
        randomize_inputs(); step();
        randomize_inputs(); step();
        rst = 0;
        nop(); iv = 1; rs = 3; ba = 32'h11; step();
        nop(); step();
        // WB bypass, then r0 stays zero
        nop(); iv = 1; rs = 5; ba = 32'hAAAA; wwe = 1; wrd = 5; wbw = 32'h1234; step();
        rs = 0; wrd = 0; step();
        // load-use: load r8, then use r8 as rt (stall once, then enters)
        nop(); iv = 1; rd = 8; mr = 1; ctrl = 8'h5A; step();
        nop(); iv = 1; rs = 1; rt = 8; rd = 9; ctrl = 8'h33; ba = 7; bb = 9; step();
        step();
        nop(); step();
        // no false stall: load to r0 then use r0; non-load r8 then use r8
        nop(); iv = 1; rd = 0; mr = 1; step();
        nop(); iv = 1; rt = 0; rs = 0; step();
        nop(); iv = 1; rd = 8; mr = 0; step();
        nop(); iv = 1; rt = 8; step();
        // flush wins over stall
        nop(); iv = 1; rd = 8; mr = 1; step();
        nop(); iv = 1; rt = 8; fl = 1; step();
        fl = 0; step();
        nop(); step();
        // saturation of the narrow counter: reset, then five load-use pairs
        rst = 1; step(); rst = 0;
        for (int k = 0; k < 5; k++) begin
            nop(); iv = 1; rd = 6; mr = 1; step();
            nop(); iv = 1; rs = 6; rd = 7; step();
            step();
        end
        nop(); step();
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 0; nop(); step();
        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage pipeline, directly downstream of the register file.
- Captures regfile read data (busA/busB), register specifiers, immediate and control bits each cycle, and presents them to EX.
- Adds a WB→ID write-through bypass. The register file writes on the clock edge, so a same-cycle read would otherwise return stale data.
- Detects load-use hazards (stall + bubble insertion), handles branch flush, and keeps a saturating stall-cycle counter.

Parameters:
CTRL_W, 8, width of the opaque EX/MEM/WB control bundle carried through
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  pipeline clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  5  source register A specifier (also drives regfile rs)
id_rt  in  5  source register B specifier (also drives regfile rt)
id_rd  in  5  destination specifier, already selected by decode
id_imm32  in  32  extended immediate
id_ctrl  in  CTRL_W  control bundle
id_memread  in  1  instruction is a load
id_busA  in  32  regfile busA
id_busB  in  32  regfile busB
wb_RegWr  in  1  WB write enable (same signal driving regfile RegWr)
wb_rd  in  5  WB destination (regfile rd)
wb_busW  in  32  WB data (regfile busW)
ex_flush  in  1  branch/jump taken in EX: kill ID instruction
ex_valid  out  1  EX slot holds a real instruction
ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
ex_busA, ex_busB  out  32 each  registered operands
ex_imm32  out  32  registered immediate
ex_ctrl  out  CTRL_W  registered control
ex_memread  out  1  registered load flag
stall  out  1  hold PC and IF/ID this cycle
stall_cnt  out  CNT_W  count of bubble cycles inserted by load-use stalls

Behaviour:
- Reset (rst=1 at posedge): all ex_* outputs = 0; stall_cnt = 0.
- stall is combinational from registered state; it is 0 in the cycle after reset because ex_valid = 0.
- Bypass (combinational, ID side):
  - opA = id_busA, except opA = wb_busW when wb_RegWr=1, wb_rd≠0 and wb_rd==id_rs.
  - opB is formed the same way against id_rt.
  - If id_rs=0, opA = 0 regardless of WB; likewise opB when id_rt=0.
- Hazard:
  - haz = ex_valid & ex_memread & (ex_rd≠0) & id_valid & ((ex_rd==id_rs) | (ex_rd==id_rt)).
  - stall = haz & ~ex_flush.
- Register update at posedge, priority top-down:
  1. rst: clear everything.
  2. ex_flush=1: bubble. ex_valid, ex_ctrl, ex_memread = 0; other fields don't-care, implemented as 0.
  3. stall=1: bubble, as in case 2. stall_cnt += 1, saturating at all-ones.
  4. Otherwise: ex_valid ← id_valid. ex_busA/B ← opA/opB. Specifiers, imm, ctrl and memread are copied.
- An id_valid=0 instruction is captured as ex_valid=0 with ex_ctrl forced 0, so it has no side effects downstream.
- Latency: 1 cycle ID→EX. Stall lasts exactly 1 cycle per load-use pair: the bubble clears the hazard next cycle.
- Flush and stall together: flush wins; stall deasserted; stall_cnt not incremented.
- Counter wrap: none; holds at 2^CNT_W−1. Cleared only by rst.
- A mid-operation rst discards any pending stall/flush with no residual state.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs → all ex_* = 0, stall=0, stall_cnt=0. Release; id_valid=1, id_rs=3, busA=0x11 → next cycle ex_valid=1, ex_busA=0x11.
2. WB bypass:
   - id_rs=5, id_busA=0xAAAA, wb_RegWr=1, wb_rd=5, wb_busW=0x1234 → ex_busA=0x1234.
   - Same with wb_rd=0, id_rs=0 → ex_busA=0.
3. Load-use:
   - Load with id_rd=8, id_memread=1, then id_rt=8 → stall=1 for exactly one cycle, then ex_valid=0 and ex_ctrl=0 (bubble). stall_cnt=1.
   - The dependent instruction enters EX on the following cycle.
4. No false stall:
   - Load to rd=0 followed by use of r0 → stall=0.
   - Non-load (memread=0) with rd=8 followed by use of r8 → stall=0.
5. Flush vs stall: load-use hazard present and ex_flush=1 in the same cycle → stall=0, bubble captured, stall_cnt unchanged.
6. Saturation: preload via CNT_W=2 build, force 5 stalls → stall_cnt reads 1,2,3,3,3.
